// File: rtl/reg_file_32x20_pkg.sv
// Shared constants and types for the 32x20 register file slice.
// Holds the default geometry, the data and address words, and the clear-engine states.
package reg_file_32x20_pkg;

   localparam int ENTRIES = 32;
   localparam int WIDTH   = 20;
   localparam int AW      = 5;

   typedef logic [WIDTH-1:0] word_t;
   typedef logic [AW-1:0]    addr_t;

   typedef enum logic {IDLE, CLEAR} state_t;

endpackage

// File: rtl/reg_file_32x20_if.sv
// Write, read and clear signals between the issue side (master) and the register file (slave).
interface reg_file_32x20_if #(
   parameter int WIDTH = reg_file_32x20_pkg::WIDTH,
   parameter int AW    = reg_file_32x20_pkg::AW
);

   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic             wr_ready;
   logic             rd0_en;
   logic [AW-1:0]    rd0_addr;
   logic [WIDTH-1:0] rd0_data;
   logic             rd0_valid;
   logic             rd1_en;
   logic [AW-1:0]    rd1_addr;
   logic [WIDTH-1:0] rd1_data;
   logic             rd1_valid;
   logic             clr_req;
   logic             busy;

   modport master (
      output wr_en, wr_addr, wr_data, rd0_en, rd0_addr, rd1_en, rd1_addr, clr_req,
      input  wr_ready, rd0_data, rd0_valid, rd1_data, rd1_valid, busy
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, rd0_en, rd0_addr, rd1_en, rd1_addr, clr_req,
      output wr_ready, rd0_data, rd0_valid, rd1_data, rd1_valid, busy
   );

endinterface

// File: rtl/reg_file_32x20_read_port.sv
// One registered read port: array select with write bypass, clear masking and zero masking.
module reg_file_read_port #(
   parameter int ENTRIES = 32,
   parameter int WIDTH   = 20,
   parameter int AW      = 5,
   parameter int ZERO_R0 = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] mem [ENTRIES],
   input  logic             wr_acc,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             clr_act,
   input  logic [AW-1:0]    clr_addr,
   output logic [WIDTH-1:0] data,
   output logic             valid
);

   import reg_file_32x20_pkg::*;

   logic [WIDTH-1:0] sel;

   // Masking beats bypass, so unmapped or hard-zero addresses never leak write data.
   always_comb begin
      sel = '0;
      if (32'(addr) >= ENTRIES || (ZERO_R0 != 0 && addr == '0))
         sel = '0;
      else if (wr_acc && wr_addr == addr)
         sel = wr_data;
      else if (clr_act && clr_addr == addr)
         sel = '0;
      else
         sel = mem[addr];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data  <= '0;
         valid <= 1'b0;
      end else begin
         valid <= en;
         if (en)
            data <= sel;
      end
   end

endmodule

// File: rtl/reg_file_32x20.sv
// 32x20 register file: one write port, two registered read ports with bypass,
// and a one-entry-per-cycle bulk-clear sweep.
module reg_file_32x20 #(
   parameter int ENTRIES = 32,
   parameter int WIDTH   = 20,
   parameter int AW      = 5,
   parameter int ZERO_R0 = 1
) (
   input logic                  clk,
   input logic                  rst,
   reg_file_32x20_if.slave      bus
);

   import reg_file_32x20_pkg::*;

   state_t           state;
   logic [AW-1:0]    cnt;
   logic             busy_q;
   logic             wr_ready_q;
   logic [WIDTH-1:0] mem [ENTRIES];
   logic             wr_acc;
   logic             wr_keep;
   logic             clr_act;

   assign bus.busy     = busy_q;
   assign bus.wr_ready = wr_ready_q;

   assign wr_acc  = bus.wr_en & wr_ready_q;
   assign wr_keep = wr_acc && (32'(bus.wr_addr) < ENTRIES) &&
                    !(ZERO_R0 != 0 && bus.wr_addr == '0);
   assign clr_act = (state == CLEAR);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         busy_q     <= 1'b0;
         wr_ready_q <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (bus.clr_req) begin
                  state      <= CLEAR;
                  cnt        <= '0;
                  busy_q     <= 1'b1;
                  wr_ready_q <= 1'b0;
               end
            end
            CLEAR: begin
               if (cnt == AW'(ENTRIES - 1)) begin
                  state      <= IDLE;
                  cnt        <= '0;
                  busy_q     <= 1'b0;
                  wr_ready_q <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Writes are only accepted in IDLE, so sweep and write never target the array together.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < ENTRIES; i++)
            mem[i] <= '0;
      end else if (clr_act) begin
         mem[cnt] <= '0;
      end else if (wr_keep) begin
         mem[bus.wr_addr] <= bus.wr_data;
      end
   end

   reg_file_read_port #(
      .ENTRIES(ENTRIES), .WIDTH(WIDTH), .AW(AW), .ZERO_R0(ZERO_R0)
   ) u_rd0 (
      .clk(clk), .rst(rst), .en(bus.rd0_en), .addr(bus.rd0_addr), .mem(mem),
      .wr_acc(wr_acc), .wr_addr(bus.wr_addr), .wr_data(bus.wr_data),
      .clr_act(clr_act), .clr_addr(cnt), .data(bus.rd0_data), .valid(bus.rd0_valid)
   );

   reg_file_read_port #(
      .ENTRIES(ENTRIES), .WIDTH(WIDTH), .AW(AW), .ZERO_R0(ZERO_R0)
   ) u_rd1 (
      .clk(clk), .rst(rst), .en(bus.rd1_en), .addr(bus.rd1_addr), .mem(mem),
      .wr_acc(wr_acc), .wr_addr(bus.wr_addr), .wr_data(bus.wr_data),
      .clr_act(clr_act), .clr_addr(cnt), .data(bus.rd1_data), .valid(bus.rd1_valid)
   );

endmodule

// File: tb/tb_reg_file_32x20.sv
// Directed bench for reg_file_32x20: reset, write/read, bypass, clear sweep and mid-sweep reset.
module tb_reg_file_32x20;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;
   int   k;

   reg_file_32x20_if bus ();

   reg_file_32x20 #(.ENTRIES(32), .WIDTH(20), .AW(5), .ZERO_R0(1)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled on the falling edge.
   task automatic step();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.wr_en   = 1'b0;
      bus.rd0_en  = 1'b0;
      bus.rd1_en  = 1'b0;
      bus.clr_req = 1'b0;
   endtask

   task automatic write(input logic [4:0] a, input logic [19:0] d);
      bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
      step();
      bus.wr_en = 1'b0;
   endtask

   task automatic read2(input logic [4:0] a0, input logic [4:0] a1);
      bus.rd0_en = 1'b1; bus.rd0_addr = a0;
      bus.rd1_en = 1'b1; bus.rd1_addr = a1;
      step();
      bus.rd0_en = 1'b0; bus.rd1_en = 1'b0;
   endtask

   initial begin
      n_checks = 0; n_fail = 0;
      rst = 1'b1;
      idle_inputs();
      bus.wr_addr = '0; bus.wr_data = '0; bus.rd0_addr = '0; bus.rd1_addr = '0;
      step(); step();
      rst = 1'b0;

      check("rst_busy", 32'(bus.busy), 0);
      check("rst_wr_ready", 32'(bus.wr_ready), 1);
      check("rst_rd0_valid", 32'(bus.rd0_valid), 0);
      check("rst_rd0_data", 32'(bus.rd0_data), 0);

      for (int i = 0; i < 32; i++) begin
         read2(5'(i), 5'(31 - i));
         check("rst_rd0_v", 32'(bus.rd0_valid), 1);
         check("rst_rd1_v", 32'(bus.rd1_valid), 1);
         check("rst_rd0_d", 32'(bus.rd0_data), 0);
         check("rst_rd1_d", 32'(bus.rd1_data), 0);
      end

      write(5'd5, 20'hABCDE);
      read2(5'd5, 5'd5);
      check("rd0_a5", 32'(bus.rd0_data), 32'h000ABCDE);
      check("rd1_same_addr", 32'(bus.rd1_data), 32'h000ABCDE);
      step();
      check("rd0_valid_drop", 32'(bus.rd0_valid), 0);
      check("rd0_data_hold", 32'(bus.rd0_data), 32'h000ABCDE);

      write(5'd0, 20'hFFFFF);
      read2(5'd0, 5'd0);
      check("r0_rd0", 32'(bus.rd0_data), 0);
      check("r0_rd1", 32'(bus.rd1_data), 0);

      write(5'd7, 20'h00001);
      bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 20'h12345;
      bus.rd1_en = 1'b1; bus.rd1_addr = 5'd7;
      step();
      idle_inputs();
      check("bypass_rd1", 32'(bus.rd1_data), 32'h00012345);
      read2(5'd7, 5'd5);
      check("after_bypass_rd0", 32'(bus.rd0_data), 32'h00012345);

      for (int i = 0; i < 32; i++)
         write(5'(i), 20'(i + 1));
      read2(5'd31, 5'd0);
      check("fill_a31", 32'(bus.rd0_data), 32'h20);
      check("fill_a0", 32'(bus.rd1_data), 0);

      bus.clr_req = 1'b1;
      step();
      bus.clr_req = 1'b0;
      k = 0;
      while (bus.busy === 1'b1 && k < 100) begin
         if (k == 16) begin
            check("sweep_wr_ready", 32'(bus.wr_ready), 0);
            bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 20'h77777;
         end
         if (k == 20) begin
            bus.rd0_en = 1'b1; bus.rd0_addr = 5'd20;
            bus.rd1_en = 1'b1; bus.rd1_addr = 5'd21;
         end
         step();
         idle_inputs();
         if (k == 20) begin
            check("clear_same_cycle", 32'(bus.rd0_data), 0);
            check("not_yet_cleared", 32'(bus.rd1_data), 32'h16);
         end
         k++;
      end
      check("busy_cycles", 32'(k), 32);
      check("post_sweep_wr_ready", 32'(bus.wr_ready), 1);
      for (int i = 0; i < 32; i++) begin
         read2(5'(i), 5'(i));
         check("post_sweep_rd0", 32'(bus.rd0_data), 0);
         check("post_sweep_rd1", 32'(bus.rd1_data), 0);
      end

      bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 20'h0AAAA;
      bus.clr_req = 1'b1;
      step();
      idle_inputs();
      check("clr_wr_busy", 32'(bus.busy), 1);
      k = 0;
      while (bus.busy === 1'b1 && k < 100) begin
         if (k == 2) begin
            bus.rd0_en = 1'b1; bus.rd0_addr = 5'd9;
         end
         if (k == 10)
            bus.clr_req = 1'b1;
         step();
         idle_inputs();
         if (k == 2)
            check("clr_wr_accepted", 32'(bus.rd0_data), 32'h0AAAA);
         k++;
      end
      check("busy_cycles_reclr", 32'(k), 32);
      read2(5'd9, 5'd9);
      check("a9_cleared", 32'(bus.rd0_data), 0);
      step();
      check("no_restart", 32'(bus.busy), 0);

      write(5'd30, 20'h55555);
      bus.clr_req = 1'b1;
      step();
      idle_inputs();
      k = 0;
      while (k < 15) begin
         if (k == 5) begin
            bus.rd1_en = 1'b1; bus.rd1_addr = 5'd30;
         end
         step();
         idle_inputs();
         if (k == 5)
            check("pre_rst_a30", 32'(bus.rd1_data), 32'h55555);
         k++;
      end
      rst = 1'b1;
      bus.wr_en = 1'b1; bus.wr_addr = 5'd2; bus.wr_data = 20'h11111;
      bus.rd0_en = 1'b1; bus.rd0_addr = 5'd30;
      bus.clr_req = 1'b1;
      step();
      rst = 1'b0;
      idle_inputs();
      check("mid_rst_busy", 32'(bus.busy), 0);
      check("mid_rst_wr_ready", 32'(bus.wr_ready), 1);
      check("mid_rst_rd0_valid", 32'(bus.rd0_valid), 0);
      check("mid_rst_rd1_data", 32'(bus.rd1_data), 0);
      step();
      check("mid_rst_clr_ignored", 32'(bus.busy), 0);
      read2(5'd30, 5'd2);
      check("mid_rst_a30", 32'(bus.rd0_data), 0);
      check("mid_rst_wr_ignored", 32'(bus.rd1_data), 0);

      bus.clr_req = 1'b1;
      step();
      idle_inputs();
      k = 0;
      while (bus.busy === 1'b1 && k < 100) begin
         step();
         k++;
      end
      check("busy_cycles_after_rst", 32'(k), 32);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
